adam_aes_enc_scheduler: RTL and testbench
=========================================

ADAM_AES_ENC_SCHEDULER -- requirements
Module: adam_aes_enc_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 63: maximum cycles spent in BUSY before abort.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid, bit i = requester i.
REQ-005 SHALL have port req_ready  output  2  per-requester accept, one-hot or zero.
REQ-006 SHALL have port req_block  input  256  plaintext; [127:0] requester 0, [255:128] requester 1.
REQ-007 SHALL have port req_keylen  input  2  key length per requester (0 = AES-128, 1 = AES-256).
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  result consumer accept.
REQ-010 SHALL have port rsp_id  output  1  requester index owning the result.
REQ-011 SHALL have port rsp_block  output  128  ciphertext.
REQ-012 SHALL have port rsp_err  output  1  1 = core timed out; rsp_block is then all-zero.
REQ-013 SHALL have port core_next  output  1  single-cycle start pulse to the encipher core.
REQ-014 SHALL have port core_keylen  output  1  key length driven to the core and key-schedule.
REQ-015 SHALL have port core_key_sel  output  1  key-bank select, equals granted requester index.
REQ-016 SHALL have port core_block  output  128  plaintext driven to the core.
REQ-017 SHALL have port core_new_block  input  128  core result.
REQ-018 SHALL have port core_ready  input  1  core idle/done flag.

Function
REQ-019 SHALL implement FSM states IDLE, START, BUSY, RESP.
REQ-020 IDLE: when any req_valid bit set and core_ready = 1, SHALL select requester by round-robin, assert req_ready for that bit only in that cycle, capture req_block slice, req_keylen bit and index, go to START.
REQ-021 Round-robin: both valid -> grant requester not granted last; one valid -> grant it; last_grant updates on every accept.
REQ-022 IDLE with core_ready = 0 SHALL hold req_ready = 0 and stay IDLE.
REQ-023 START: core_next = 1 for exactly one cycle; go to BUSY; core_block, core_keylen, core_key_sel SHALL be held stable from START until leaving BUSY.
REQ-024 BUSY: SHALL set internal flag seen_busy when core_ready = 0; completion = seen_busy AND core_ready = 1; ready high before seen_busy SHALL be ignored.
REQ-025 On completion: capture core_new_block into rsp_block, rsp_err = 0, go to RESP.
REQ-026 BUSY cycle counter SHALL start at 0 on BUSY entry, increment each BUSY cycle; reaching TIMEOUT_CYC without completion -> rsp_block = 0, rsp_err = 1, go to RESP.
REQ-027 RESP: rsp_valid = 1, rsp_id/rsp_block/rsp_err stable; on rsp_ready = 1 go to IDLE; rsp_valid deasserts next cycle.
REQ-028 Latency: request accept to core_next = 1 cycle; core_ready rise (after seen_busy) to rsp_valid = 1 cycle.
REQ-029 No new request SHALL be accepted in START, BUSY or RESP; req_ready = 0 there.
REQ-030 req_valid changing during non-IDLE states SHALL have no effect.
REQ-031 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-032 Reset SHALL force IDLE; req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_err = 0, rsp_block = 0, core_next = 0, core_block = 0, core_keylen = 0, core_key_sel = 0, counter = 0, seen_busy = 0, last_grant = 1 (requester 0 wins first tie).
REQ-033 Reset mid-operation SHALL discard the in-flight request and pending result with no rsp_valid pulse.

Verification
REQ-034 Both req_valid = 2'b11 after reset, core model 14-cycle latency -> first grant req 0, then req 1; rsp_id sequence 0,1.
REQ-035 Req 0 only, FIPS-197 AES-128 vector 00112233445566778899aabbccddeeff with key 000102..0f -> rsp_block 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err = 0.
REQ-036 Core model never raises core_ready -> rsp_valid after TIMEOUT_CYC BUSY cycles, rsp_err = 1, rsp_block = 0.
REQ-037 rsp_ready held 0 for 10 cycles in RESP, req_valid = 2'b10 -> req_ready stays 0, rsp outputs stable; accept only after rsp_ready.
REQ-038 Core_ready held 1 for 2 BUSY cycles before dropping -> no premature completion; result taken on later rise.
REQ-039 reset_n low during BUSY -> all outputs at reset values next edge; no rsp_valid.

Source files
------------

// File: rtl/adam_aes_enc_scheduler.sv
// Two-requester round-robin front end for a single AES encipher core.
// Each request is served from grant to response, with a BUSY timeout that aborts stuck operations.
module adam_aes_enc_scheduler #(
  parameter int TIMEOUT_CYC = 63
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [255:0] req_block,
  input  logic [1:0]   req_keylen,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_block,
  output logic         rsp_err,
  output logic         core_next,
  output logic         core_keylen,
  output logic         core_key_sel,
  output logic [127:0] core_block,
  input  logic [127:0] core_new_block,
  input  logic         core_ready
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            last_grant_r;
  logic            grant_s;
  logic            accept_s;
  logic            done_s;
  logic            timeout_s;
  logic            seen_busy_r;
  logic [CW-1:0]   cnt_r;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, arbitration and the combinational accept handshake
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = 2'b00;
    grant_s     = 1'b0;
    accept_s    = 1'b0;
    done_s      = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid == 2'b11) begin
          grant_s = ~last_grant_r;
        end else begin
          grant_s = req_valid[1];
        end
        if ((req_valid != 2'b00) && core_ready) begin
          accept_s    = 1'b1;
          req_ready   = grant_s ? 2'b10 : 2'b01;
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        state_nxt_s = BUSY;
      end
      BUSY: begin
        // A ready flag still high from the previous op must not count as done.
        done_s    = seen_busy_r && core_ready;
        timeout_s = !done_s && (cnt_r == CW'(TIMEOUT_CYC - 1));
        if (done_s || timeout_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Request capture towards the core, plus round-robin history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= 1'b1;
      core_next    <= 1'b0;
      core_block   <= 128'h0;
      core_keylen  <= 1'b0;
      core_key_sel <= 1'b0;
    end else begin
      core_next <= accept_s;
      if (accept_s) begin
        last_grant_r <= grant_s;
        core_block   <= grant_s ? req_block[255:128] : req_block[127:0];
        core_keylen  <= req_keylen[grant_s];
        core_key_sel <= grant_s;
      end
    end
  end

  // BUSY bookkeeping: cycle counter and the core-went-busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r       <= '0;
      seen_busy_r <= 1'b0;
    end else if (state_r == START) begin
      cnt_r       <= '0;
      seen_busy_r <= 1'b0;
    end else if (state_r == BUSY) begin
      cnt_r <= cnt_r + CW'(1);
      if (!core_ready) begin
        seen_busy_r <= 1'b1;
      end
    end
  end

  // Response registers, loaded on completion or timeout and held through RESP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_block <= 128'h0;
      rsp_err   <= 1'b0;
    end else if (done_s) begin
      rsp_valid <= 1'b1;
      rsp_id    <= core_key_sel;
      rsp_block <= core_new_block;
      rsp_err   <= 1'b0;
    end else if (timeout_s) begin
      rsp_valid <= 1'b1;
      rsp_id    <= core_key_sel;
      rsp_block <= 128'h0;
      rsp_err   <= 1'b1;
    end else if ((state_r == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adam_aes_enc_scheduler.sv
// Randomized bench for adam_aes_enc_scheduler with a transaction-level reference model
// and a scripted core model (ready-high lead, busy duration, optional hang).
module tb_adam_aes_enc_scheduler;

  localparam int T = 63;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         reset_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [255:0] req_block;
  logic [1:0]   req_keylen;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [127:0] rsp_block;
  logic         rsp_err;
  logic         core_next;
  logic         core_keylen;
  logic         core_key_sel;
  logic [127:0] core_block;
  logic [127:0] core_new_block;
  logic         core_ready;

  int   checks = 0;
  int   errors = 0;
  logic m_last = 1'b1;

  adam_aes_enc_scheduler #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_block(req_block), .req_keylen(req_keylen),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_block(rsp_block),
    .rsp_err(rsp_err), .core_next(core_next), .core_keylen(core_keylen),
    .core_key_sel(core_key_sel), .core_block(core_block),
    .core_new_block(core_new_block), .core_ready(core_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stand-in cipher: the real FIPS-197 answer for the known vector, a fixed mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] b, input logic kl);
    if (b == FIPS_PT && kl == 1'b0) return FIPS_CT;
    return {b[95:0], b[127:96]} ^ {4{kl ? 32'h3c3c_a5a5 : 32'h0f1e_2d3b}};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, req_ready, 2'b00);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_id"}, rsp_id, 1'b0);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_rsp_block"}, rsp_block, 128'h0);
    check({tag, "_core_next"}, core_next, 1'b0);
    check({tag, "_core_block"}, core_block, 128'h0);
    check({tag, "_core_keylen"}, core_keylen, 1'b0);
    check({tag, "_core_key_sel"}, core_key_sel, 1'b0);
  endtask

  // One full request: grant, core run (p_hi ready-high cycles, then l_lo busy cycles,
  // l_lo < 0 = never finishes), response held rsp_wait cycles, then consumed.
  task automatic run_txn(input logic [1:0] vld, input logic [127:0] b0, input logic [127:0] b1,
                         input logic [1:0] kl, input int p_hi, input int l_lo,
                         input int rsp_wait, input logic [1:0] vld_in, input logic rsp_noise);
    logic         g;
    logic         ekl;
    logic         eerr;
    logic [127:0] eb;
    logic [127:0] eres;
    int           busy_total;
    int           exp_busy;
    int           c;
    bit           ok;
    bit           got;

    g          = (vld == 2'b11) ? ~m_last : vld[1];
    m_last     = g;
    eb         = g ? b1 : b0;
    ekl        = kl[g];
    busy_total = (l_lo < 0) ? 100000 : p_hi + l_lo + 1;
    eerr       = busy_total > T;
    exp_busy   = eerr ? T : busy_total;
    eres       = eerr ? 128'h0 : core_fn(eb, ekl);

    req_valid  = vld;
    req_block  = {b1, b0};
    req_keylen = kl;
    #1;
    check("req_ready_grant", req_ready, g ? 2'b10 : 2'b01);
    step();
    req_valid = vld_in;
    #1;
    check("core_next_start", core_next, 1'b1);
    check("core_block", core_block, eb);
    check("core_keylen", core_keylen, ekl);
    check("core_key_sel", core_key_sel, g);
    check("req_ready_start", req_ready, 2'b00);

    ok  = 1'b1;
    got = 1'b0;
    c   = 0;
    while (!got && c < T + 10) begin
      step();
      c++;
      if (c <= p_hi) begin
        core_ready = 1'b1;
      end else if (l_lo < 0 || c <= p_hi + l_lo) begin
        core_ready = 1'b0;
      end else begin
        core_ready     = 1'b1;
        core_new_block = core_fn(eb, ekl);
      end
      rsp_ready = rsp_noise && (c <= exp_busy);
      #1;
      if (rsp_valid) begin
        got = 1'b1;
      end else if (core_next || req_ready != 2'b00 || core_block !== eb ||
                   core_key_sel !== g || core_keylen !== ekl) begin
        ok = 1'b0;
      end
    end
    rsp_ready = 1'b0;
    check("busy_stable", ok, 1'b1);
    check("rsp_latency", c, exp_busy + 1);
    check("rsp_id", rsp_id, g);
    check("rsp_err", rsp_err, eerr);
    check("rsp_block", rsp_block, eres);

    ok = 1'b1;
    for (int i = 0; i < rsp_wait; i++) begin
      step();
      #1;
      if (!rsp_valid || req_ready != 2'b00 || rsp_id !== g || rsp_block !== eres || rsp_err !== eerr)
        ok = 1'b0;
    end
    check("resp_hold", ok, 1'b1);
    step();
    req_valid  = 2'b00;
    rsp_ready  = 1'b1;
    core_ready = 1'b1;
    #1;
    check("rsp_valid_pre_accept", rsp_valid, 1'b1);
    step();
    rsp_ready = 1'b0;
    #1;
    check("rsp_valid_drop", rsp_valid, 1'b0);
  endtask

  initial begin
    bit ok;
    reset_n        = 1'b0;
    req_valid      = 2'b00;
    req_block      = 256'h0;
    req_keylen     = 2'b00;
    rsp_ready      = 1'b0;
    core_ready     = 1'b1;
    core_new_block = 128'h0;
    repeat (3) step();
    check_reset_values("reset");
    reset_n = 1'b1;
    step();

    // Core not ready: requests must wait in IDLE.
    req_valid  = 2'b01;
    core_ready = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      if (req_ready != 2'b00 || core_next) ok = 1'b0;
    end
    check("idle_core_not_ready", ok, 1'b1);
    req_valid  = 2'b00;
    core_ready = 1'b1;
    step();

    // Tie after reset: requester 0 first, then 1.
    run_txn(2'b11, 128'h1111, 128'h2222, 2'b10, 0, 14, 0, 2'b11, 1'b0);
    run_txn(2'b11, 128'h3333, 128'h4444, 2'b01, 0, 14, 0, 2'b00, 1'b0);
    // FIPS-197 known answer.
    run_txn(2'b01, FIPS_PT, 128'h0, 2'b00, 0, 10, 1, 2'b00, 1'b0);
    // Hung core: timeout abort.
    run_txn(2'b10, 128'h0, 128'hdeadbeef, 2'b00, 0, -1, 0, 2'b00, 1'b1);
    // Consumer stalls 10 cycles while requester 1 waits.
    run_txn(2'b01, 128'h5555, 128'h6666, 2'b11, 0, 6, 10, 2'b10, 1'b0);
    // Stale ready for 2 BUSY cycles before the core goes busy.
    run_txn(2'b10, 128'h7777, 128'h8888, 2'b10, 2, 5, 0, 2'b01, 1'b1);

    for (int n = 0; n < 20; n++) begin
      run_txn(2'($urandom_range(1, 3)),
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              2'($urandom_range(0, 3)),
              $urandom_range(0, 3), $urandom_range(1, 20), $urandom_range(0, 4),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset while BUSY drops the request.
    req_valid = 2'b01;
    req_block = {128'h0, 128'habcdef};
    #1;
    step();
    req_valid = 2'b00;
    step();
    core_ready = 1'b0;
    repeat (3) step();
    reset_n = 1'b0;
    m_last  = 1'b1;
    #1;
    check_reset_values("midreset");
    core_ready = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid || core_next) ok = 1'b0;
    end
    check("no_rsp_after_reset", ok, 1'b1);
    run_txn(2'b11, 128'h9999, 128'haaaa, 2'b11, 1, 3, 0, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
